tpu_serial_host: RTL and testbench
==================================

TPU_SERIAL_HOST -- requirements
Module: tpu_serial_host

Interface
REQ-001 SHALL have parameter N, default 8, meaning TPU register data width in bits.
REQ-002 SHALL have parameter K, default 16, meaning TPU register count; AW = $clog2(K) and frame length F = 1+AW+N.
REQ-003 SHALL have port s_clk  input  1  meaning the single clock; all logic rising-edge.
REQ-004 SHALL have port s_rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  meaning a host request is present.
REQ-006 SHALL have port req_ready  output  1  meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  meaning 1 = register write, 0 = register read.
REQ-008 SHALL have port req_addr  input  AW  meaning the target register index.
REQ-009 SHALL have port req_wdata  input  N  meaning the write data.
REQ-010 SHALL have port rsp_valid  output  1  meaning a response is held.
REQ-011 SHALL have port rsp_ready  input  1  meaning the host consumes the response.
REQ-012 SHALL have port rsp_rdata  output  N  meaning read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err  output  1  meaning the request was rejected.
REQ-014 SHALL have port busy  output  1  meaning the state is not IDLE.
REQ-015 SHALL have port tpu_update  output  1  meaning drives the TPU s_update.
REQ-016 SHALL have port tpu_sin  output  1  meaning drives the TPU s_in.
REQ-017 SHALL have port tpu_sout  input  1  meaning sampled from the TPU s_out.

Function
REQ-018 SHALL implement states IDLE, SHIFT, UPDATE, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept on req_valid&&req_ready (cycle 0); frame = {req_write, req_addr, req_wdata (zeros for reads)}, MSB first.
REQ-020 SHALL, in SHIFT cycles 1..F, drive tpu_sin with frame bit F-1 down to 0, with tpu_update=0.
REQ-021 SHALL, in UPDATE cycle F+1, drive tpu_update=1 and tpu_sin=0 for exactly one cycle.
REQ-022 SHALL, for writes, go UPDATE->RESP, with rsp_valid=1 from cycle F+2.
REQ-023 SHALL, for reads, go UPDATE->CAPTURE for cycles F+2..F+N+1, shifting tpu_sout into rsp_rdata MSB first at each edge, with tpu_sin=0; rsp_valid=1 from cycle F+N+2.
REQ-024 SHALL, when req_addr >= K, not shift and not pulse tpu_update; it SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0, and rsp_valid=1 in cycle 1.
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge; back-to-back acceptance is possible the next cycle.
REQ-026 SHALL ignore req_* outside IDLE; the bit counter SHALL use ceil(log2(F+1)) bits and never wrap.
REQ-027 SHALL assert tpu_update only in UPDATE and tpu_sin only in SHIFT.

Reset
REQ-028 SHALL, with s_rst_n=0 at an edge, enter IDLE and clear rsp_valid, rsp_err, rsp_rdata, busy, tpu_update, tpu_sin and the counters; req_ready=1 on the first cycle after release.
REQ-029 SHALL, on reset mid-frame, discard the partial frame with no further tpu_update pulse; reset dominates a simultaneous handshake.

Configuration
REQ-030 SHALL, when TPU_HOST_READ_EN is defined, implement reads per REQ-023.
REQ-031 SHALL, when TPU_HOST_READ_EN is undefined, answer reads like REQ-024 (rsp_err=1, no serial activity) and omit CAPTURE logic.

Structure
REQ-032 SHALL take the state enum, the WRITE/READ opcode constants and a frame-length function from shared package tpu_pkg.
REQ-033 SHALL contain one sub-module, tpu_shift_reg, a width-parameterised PISO/SIPO shift register with load and shift enables.

Verification (N=8, K=12, AW=4, F=13)
REQ-034 SHALL test a write of 0xA5 to addr 3: tpu_sin = 1,0011,10100101 in cycles 1..13; tpu_update=1 in cycle 14 only; rsp_valid in cycle 15 with err=0 and rdata=0.
REQ-035 SHALL test a read of addr 3 with a TPU model returning 0x5A on tpu_sout in cycles 15..22: rsp_valid in cycle 23 with rdata=0x5A and err=0.
REQ-036 SHALL test a request to addr 13: rsp_valid in cycle 1 with err=1; tpu_sin and tpu_update stay 0 throughout.
REQ-037 SHALL test rsp_ready held low for 5 cycles: the response stays stable, req_ready=0, and new req_valid is ignored.
REQ-038 SHALL test s_rst_n=0 at cycle 7 of a write: the next cycle has all outputs at reset values, no tpu_update ever, and req_ready=1 after release.
REQ-039 SHALL test a read of addr 2 with TPU_HOST_READ_EN undefined: rsp_valid in cycle 1 with err=1 and no serial activity.

Source files
------------

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared FSM states, WRITE/READ opcodes and frame-length helper for the TPU serial host
package tpu_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, UPDATE, CAPTURE, RESP} state_t;
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ = 1'b0;
  function automatic int frame_len(input int n, input int k);
    return 1 + $clog2(k) + n;
  endfunction
endpackage

// File: rtl/tpu_shift_reg.sv
// tpu_shift_reg: W-bit PISO/SIPO shift register (clk, rst_n sync low, load d, shift MSB-out/sin-in, q)
module tpu_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[W-2:0], sin};
endmodule

// File: rtl/tpu_serial_host.sv
// tpu_serial_host: req/rsp register host serialising {write,addr,data} frames to a TPU (tpu_sin/tpu_update out, tpu_sout in); reads only with TPU_HOST_READ_EN
module tpu_serial_host
  import tpu_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 16,
  localparam int AW = $clog2(K)
) (
  input  logic          s_clk,
  input  logic          s_rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          tpu_update,
  output logic          tpu_sin,
  input  logic          tpu_sout
);
  localparam int F = frame_len(N, K);
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(F - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic err_q, bad, load, shift, sin, unused_q;
  logic [F-1:0] frame, q;
  assign frame = {req_write, req_addr, req_write == OP_WRITE ? req_wdata : N'(0)};
  assign load = state == IDLE && req_valid;
  assign unused_q = ^q[F-2:N];
`ifdef TPU_HOST_READ_EN
  localparam logic [CW-1:0] LAST_CAP = CW'(N - 1);
  logic wr_q;
  assign bad = 32'(req_addr) >= K;
  assign shift = state == SHIFT || state == CAPTURE;
  assign sin = state == CAPTURE && tpu_sout;
`else
  logic unused_sout;
  assign unused_sout = tpu_sout;
  assign bad = 32'(req_addr) >= K || req_write == OP_READ;
  assign shift = state == SHIFT;
  assign sin = 1'b0;
`endif
  tpu_shift_reg #(.W(F)) u_sr (
    .clk  (s_clk),
    .rst_n(s_rst_n),
    .load (load),
    .shift(shift),
    .sin  (sin),
    .d    (bad ? '0 : frame),
    .q    (q)
  );
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign tpu_update = state == UPDATE;
  assign tpu_sin = state == SHIFT && q[F-1];
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? q[N-1:0] : '0;
  always_ff @(posedge s_clk)
    if (!s_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
`ifdef TPU_HOST_READ_EN
      wr_q <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (req_valid) begin
          state <= bad ? RESP : SHIFT;
          err_q <= bad;
          cnt <= '0;
`ifdef TPU_HOST_READ_EN
          wr_q <= req_write;
`endif
        end
        SHIFT: begin
          state <= cnt == LAST_SHIFT ? UPDATE : SHIFT;
          cnt <= cnt == LAST_SHIFT ? '0 : cnt + 1'b1;
        end
`ifdef TPU_HOST_READ_EN
        UPDATE: state <= wr_q == OP_WRITE ? RESP : CAPTURE;
        CAPTURE: begin
          state <= cnt == LAST_CAP ? RESP : CAPTURE;
          cnt <= cnt == LAST_CAP ? '0 : cnt + 1'b1;
        end
`else
        UPDATE: state <= RESP;
`endif
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_tpu_serial_host.sv
// tb_tpu_serial_host: directed table, reset and random checks of tpu_serial_host against a TPU register-file model
module tb_tpu_serial_host;
  localparam int N = 8;
  localparam int K = 12;
  localparam int AW = 4;
  localparam int F = 13;
`ifdef TPU_HOST_READ_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif
  typedef struct {
    logic wr;
    logic [AW-1:0] addr;
    logic [N-1:0] wd;
    int hold;
    int rc;
    logic err;
    logic [N-1:0] rd;
  } vec_t;
  logic s_clk = 1'b0, s_rst_n = 1'b0, req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0, tpu_sout = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, busy, tpu_update, tpu_sin;
  logic [N-1:0] rsp_rdata;
  int cmp_n = 0, err_n = 0;
  logic [N-1:0] ref_mem [K];
  logic [N-1:0] tpu_mem [K];
  logic [F-1:0] hist = '0;
  logic [AW-1:0] tpu_a;
  bit sq[$];
  vec_t tbl [11];
  always #5 s_clk = ~s_clk;
  tpu_serial_host #(.N(N), .K(K)) dut (
    .s_clk     (s_clk),
    .s_rst_n   (s_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .tpu_update(tpu_update),
    .tpu_sin   (tpu_sin),
    .tpu_sout  (tpu_sout)
  );
  always @(posedge s_clk) begin
    if (!s_rst_n) begin
      hist <= '0;
      sq.delete();
      tpu_sout <= 1'b0;
    end else if (tpu_update) begin
      tpu_a = hist[F-2:N];
      if (hist[F-1]) begin
        if (tpu_a < K) tpu_mem[tpu_a] = hist[N-1:0];
        tpu_sout <= 1'($urandom);
      end else begin
        for (int i = N - 1; i >= 0; i--) sq.push_back(tpu_a < K ? tpu_mem[tpu_a][i] : 1'b0);
        tpu_sout <= sq.pop_front();
      end
    end else begin
      hist <= {hist[F-2:0], tpu_sin};
      tpu_sout <= sq.size() > 0 ? sq.pop_front() : 1'($urandom);
    end
  end
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    cmp_n++;
    if (a !== e) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [N-1:0] wd, input int hold,
                     input int exp_rc, input logic exp_err, input logic [N-1:0] exp_rd, input string tag,
                     output logic [F-1:0] seq);
    logic [63:0] sin_v, upd_v, exp_sin, exp_upd;
    logic [F-1:0] fr;
    int rc;
    sin_v = '0;
    upd_v = '0;
    exp_sin = '0;
    exp_upd = '0;
    seq = '0;
    rc = 0;
    chk($sformatf("%s.ready", tag), 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_write = wr;
    req_addr = addr;
    req_wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge s_clk);
      if (c == 1) chk($sformatf("%s.busy", tag), 64'(busy), 64'(1));
      sin_v[c] = tpu_sin;
      upd_v[c] = tpu_update;
      if (c <= F) seq = {seq[F-2:0], tpu_sin};
      req_write = 1'($urandom);
      req_addr = 4'($urandom);
      req_wdata = 8'($urandom);
      if (rsp_valid) begin
        rc = c;
        break;
      end
    end
    chk($sformatf("%s.rsp_cycle", tag), 64'(rc), 64'(exp_rc));
    chk($sformatf("%s.err", tag), 64'(rsp_err), 64'(exp_err));
    chk($sformatf("%s.rdata", tag), 64'(rsp_rdata), 64'(exp_rd));
    if (!exp_err) begin
      fr = {wr, addr, wr ? wd : 8'h00};
      for (int i = 1; i <= F; i++) exp_sin[i] = fr[F-i];
      exp_upd[F+1] = 1'b1;
    end
    chk($sformatf("%s.sin", tag), sin_v, exp_sin);
    chk($sformatf("%s.update", tag), upd_v, exp_upd);
    for (int h = 1; h <= hold; h++) begin
      @(negedge s_clk);
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr = 4'($urandom);
      chk($sformatf("%s.hold%0d", tag, h), {rsp_valid, req_ready, rsp_err, rsp_rdata}, {1'b1, 1'b0, exp_err, exp_rd});
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge s_clk);
    rsp_ready = 1'b0;
    chk($sformatf("%s.release", tag), {rsp_valid, req_ready, busy}, 3'b010);
    if (!exp_err && wr) ref_mem[addr] = wd;
  endtask
  initial begin
    logic [F-1:0] seq;
    logic wr;
    logic [AW-1:0] addr;
    logic [N-1:0] wd;
    logic bad;
    int upd_cnt;
    for (int i = 0; i < K; i++) begin
      ref_mem[i] = '0;
      tpu_mem[i] = '0;
    end
    tbl[0] = '{1'b1, 4'd3, 8'hA5, 0, 15, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 4'd3, 8'h5A, 5, 15, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 4'd3, 8'h00, 0, RD ? 23 : 1, !RD, RD ? 8'h5A : 8'h00};
    tbl[3] = '{1'b1, 4'd13, 8'h77, 2, 1, 1'b1, 8'h00};
    tbl[4] = '{1'b0, 4'd13, 8'h00, 0, 1, 1'b1, 8'h00};
    tbl[5] = '{1'b1, 4'd11, 8'hFF, 0, 15, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 4'd12, 8'h11, 0, 1, 1'b1, 8'h00};
    tbl[7] = '{1'b0, 4'd11, 8'h00, 1, RD ? 23 : 1, !RD, RD ? 8'hFF : 8'h00};
    tbl[8] = '{1'b0, 4'd2, 8'h00, 0, RD ? 23 : 1, !RD, 8'h00};
    tbl[9] = '{1'b1, 4'd0, 8'hC3, 0, 15, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 4'd0, 8'h00, 3, RD ? 23 : 1, !RD, RD ? 8'hC3 : 8'h00};
    repeat (3) @(negedge s_clk);
    chk("reset_outputs", {rsp_valid, rsp_err, rsp_rdata, busy, tpu_update, tpu_sin, req_ready}, {13'b0, 1'b1});
    s_rst_n = 1'b1;
    @(negedge s_clk);
    chk("ready_after_reset", 64'(req_ready), 64'(1));
    for (int v = 0; v < 11; v++) begin
      txn(tbl[v].wr, tbl[v].addr, tbl[v].wd, tbl[v].hold, tbl[v].rc, tbl[v].err, tbl[v].rd, $sformatf("vec%0d", v), seq);
      if (v == 0) chk("vec0.frame_bits", 64'(seq), 64'(13'b1_0011_10100101));
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 4'd5;
    req_wdata = 8'h33;
    upd_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge s_clk);
      req_valid = 1'b0;
      upd_cnt += int'(tpu_update);
    end
    s_rst_n = 1'b0;
    req_valid = 1'b1;
    req_addr = 4'd1;
    @(negedge s_clk);
    chk("rst_mid.outputs", {rsp_valid, rsp_err, rsp_rdata, busy, tpu_update, tpu_sin, req_ready}, {13'b0, 1'b1});
    @(negedge s_clk);
    chk("rst_mid.handshake_ignored", 64'(busy), 64'(0));
    s_rst_n = 1'b1;
    req_valid = 1'b0;
    @(negedge s_clk);
    chk("rst_mid.ready", 64'(req_ready), 64'(1));
    for (int c = 0; c < 30; c++) begin
      @(negedge s_clk);
      upd_cnt += int'(tpu_update);
    end
    chk("rst_mid.no_update", 64'(upd_cnt), 64'(0));
    txn(1'b0, 4'd5, 8'h00, 0, RD ? 23 : 1, !RD, 8'h00, "rst_mid.readback", seq);
    for (int r = 0; r < 40; r++) begin
      wr = 1'($urandom);
      addr = 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      bad = addr >= K || (!wr && !RD);
      txn(wr, addr, wd, $urandom_range(0, 3), bad ? 1 : (wr ? F + 2 : F + N + 2), bad,
          (bad || wr) ? 8'h00 : ref_mem[addr], $sformatf("rnd%0d", r), seq);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
